// File: rtl/axi_rd_slv.sv
// -----------------------------------------------------------------------------
// axi_rd_slv
//   Read-only AXI slave endpoint (AR + R channels) with a DEPTH-entry AR queue
//   and incrementing bursts. Every AR is accepted while the queue has room.
//   Bursts whose start address falls inside [BASE_ADDR, BASE_ADDR+RANGE) return
//   OKAY with the beat address as data; all other bursts return DECERR with zero
//   data.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   axi_slv_ar*       AR channel: id, start address, len (beats-1), valid/ready
//   axi_slv_r*        R channel: id, data, resp, last, valid/ready
//   axi_slv_q_cnt     number of queued AR entries not yet taken into service
// -----------------------------------------------------------------------------
module axi_rd_slv #(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W:0]   RANGE     = (ADDR_W+1)'('h1000)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ID_W-1:0]            axi_slv_arid,
    input  logic [ADDR_W-1:0]          axi_slv_araddr,
    input  logic [7:0]                 axi_slv_arlen,
    input  logic                       axi_slv_arvalid,
    output logic                       axi_slv_arready,
    output logic [ID_W-1:0]            axi_slv_rid,
    output logic [DATA_W-1:0]          axi_slv_rdata,
    output logic [1:0]                 axi_slv_rresp,
    output logic                       axi_slv_rlast,
    output logic                       axi_slv_rvalid,
    input  logic                       axi_slv_rready,
    output logic [$clog2(DEPTH):0]     axi_slv_q_cnt
);

    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Beat address to data word: zero-extend or truncate to DATA_W.
    function automatic logic [DATA_W-1:0] addr_to_data(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    // Queue storage and pointers
    logic [ID_W-1:0]   id_mem_q   [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [7:0]        len_mem_q  [DEPTH];
    logic              hit_mem_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  q_cnt_q, q_cnt_d;

    // Engine state and working registers
    state_t            state_q, state_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [7:0]        len_q, len_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;

    // Registered R outputs
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              rvalid_q, rvalid_d;

    logic              arready_s;
    logic              push_s;
    logic              pop_s;
    logic              ar_hit_s;
    logic [ADDR_W-1:0] ar_offset_s;

    assign arready_s   = (q_cnt_q != CNT_W'(DEPTH));
    assign push_s      = axi_slv_arvalid & arready_s;
    assign ar_offset_s = axi_slv_araddr - BASE_ADDR;
    // Only the start address is decoded; a burst running past the window end stays OKAY.
    assign ar_hit_s    = (axi_slv_araddr >= BASE_ADDR) && ({1'b0, ar_offset_s} < RANGE);

    assign axi_slv_arready = arready_s;
    assign axi_slv_q_cnt   = q_cnt_q;
    assign axi_slv_rid     = rid_q;
    assign axi_slv_rdata   = rdata_q;
    assign axi_slv_rresp   = rresp_q;
    assign axi_slv_rlast   = rlast_q;
    assign axi_slv_rvalid  = rvalid_q;

    // Queue entry write on AR handshake
    always_ff @(posedge clk) begin
        if (push_s) begin
            id_mem_q[wr_ptr_q]   <= axi_slv_arid;
            addr_mem_q[wr_ptr_q] <= axi_slv_araddr;
            len_mem_q[wr_ptr_q]  <= axi_slv_arlen;
            hit_mem_q[wr_ptr_q]  <= ar_hit_s;
        end
    end

    // Write pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        q_cnt_d  = q_cnt_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   q_cnt_d = q_cnt_q + CNT_W'(1);
            2'b01:   q_cnt_d = q_cnt_q - CNT_W'(1);
            default: q_cnt_d = q_cnt_q;
        endcase
    end

    // R engine next-state and output logic
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        hit_d       = hit_q;
        beat_addr_d = beat_addr_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rvalid_d    = rvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (q_cnt_q != CNT_W'(0)) begin
                    pop_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (axi_slv_rready) begin
                    if (!rlast_q) begin
                        beat_cnt_d  = beat_cnt_q + 8'd1;
                        beat_addr_d = beat_addr_q + STRIDE;
                        rdata_d     = hit_q ? addr_to_data(beat_addr_d) : {DATA_W{1'b0}};
                        rlast_d     = ((beat_cnt_q + 8'd1) == len_q);
                    end else if (q_cnt_q != CNT_W'(0)) begin
                        // Zero-bubble hand-over to the next queued burst
                        pop_s = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end
                end else begin
                    // Stall: every R output holds its value
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        endcase

        // Load the queue head into the working registers and first-beat outputs
        if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            state_d     = ST_BURST;
            rvalid_d    = 1'b1;
            rid_d       = id_mem_q[rd_ptr_q];
            len_d       = len_mem_q[rd_ptr_q];
            hit_d       = hit_mem_q[rd_ptr_q];
            beat_cnt_d  = 8'd0;
            beat_addr_d = addr_mem_q[rd_ptr_q];
            rdata_d     = hit_mem_q[rd_ptr_q] ? addr_to_data(addr_mem_q[rd_ptr_q]) : {DATA_W{1'b0}};
            rresp_d     = hit_mem_q[rd_ptr_q] ? RESP_OKAY : RESP_DECERR;
            rlast_d     = (len_mem_q[rd_ptr_q] == 8'd0);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State, pointer, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            q_cnt_q     <= {CNT_W{1'b0}};
            state_q     <= ST_IDLE;
            beat_cnt_q  <= 8'd0;
            len_q       <= 8'd0;
            hit_q       <= 1'b0;
            beat_addr_q <= {ADDR_W{1'b0}};
            rid_q       <= {ID_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            rresp_q     <= 2'b00;
            rlast_q     <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            q_cnt_q     <= q_cnt_d;
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            hit_q       <= hit_d;
            beat_addr_q <= beat_addr_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            rvalid_q    <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_slv.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_slv
//   Scoreboard bench for axi_rd_slv with default parameters (DATA_W=32,
//   DEPTH=4, window 0x0..0xFFF). Expected beats are pushed when an AR is
//   driven and compared as R beats are accepted.
// -----------------------------------------------------------------------------
module tb_axi_rd_slv;

    logic        clk;
    logic        rst_n;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [2:0]  q_cnt;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    axi_rd_slv dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_q_cnt   (q_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected beats of one burst
    task automatic model_push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        beat_t b;
        logic  hit;
        hit = (addr < 32'h0000_1000);
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.data = hit ? (addr + 32'(i * 4)) : 32'h0;
            b.resp = hit ? 2'b00 : 2'b11;
            b.last = (i == int'(len));
            sb_q.push_back(b);
        end
    endtask

    // Monitor: compare accepted beats and check stability across stalls
    logic        prev_stall;
    beat_t       prev_beat;
    always @(negedge clk) begin
        beat_t exp_b;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", {63'd0, rvalid}, 64'd1);
                check_eq("stall_hold", {25'd0, rid, rdata, rresp, rlast}, {25'd0, prev_beat});
            end
            if (rvalid && rready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    exp_b = sb_q.pop_front();
                    check_eq("beat", {25'd0, rid, rdata, rresp, rlast}, {25'd0, exp_b});
                end
            end
            prev_stall = rvalid && !rready;
            prev_beat  = {rid, rdata, rresp, rlast};
        end
    end

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        model_push(id, addr, len);
        n = 0;
        @(negedge clk);
        while (!arready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_eq("ar_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || rvalid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {63'd0, (n >= 2000)}, 64'd0);
    endtask

    // Single hit with exact latency: id=3 addr=0x10 len=0
    task automatic single_hit(input string tag);
        @(posedge clk); #1;
        arid = 4'd3; araddr = 32'h10; arlen = 8'd0; arvalid = 1'b1;
        model_push(4'd3, 32'h10, 8'd0);
        @(negedge clk);
        check_eq({tag, "_arready"}, {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_lat1_rvalid"}, {63'd0, rvalid}, 64'd0);
        check_eq({tag, "_lat1_qcnt"}, {61'd0, q_cnt}, 64'd1);
        @(negedge clk);
        check_eq({tag, "_lat2_rvalid"}, {63'd0, rvalid}, 64'd1);
        wait_drain({tag, "_drain"});
    endtask

    initial begin
        rst_n = 1'b0; arid = 4'd0; araddr = 32'd0; arlen = 8'd0;
        arvalid = 1'b0; rready = 1'b1;
        prev_stall = 1'b0; prev_beat = '0;
        #23;
        check_eq("rst_arready", {63'd0, arready}, 64'd1);
        check_eq("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check_eq("rst_outs", {25'd0, rid, rdata, rresp, rlast}, 64'd0);
        check_eq("rst_qcnt", {61'd0, q_cnt}, 64'd0);
        rst_n = 1'b1;

        single_hit("hit");

        // Burst with stalls
        fork
            ar_send(4'd5, 32'h100, 8'd3);
            begin
                for (int i = 0; i < 30; i++) begin
                    @(posedge clk); #1;
                    rready = (($urandom_range(0, 1) == 0) || (i % 3 == 0)) ? ~rready : rready;
                end
            end
        join
        rready = 1'b1;
        wait_drain("stall_drain");

        // Decode miss, and a hit burst crossing the window end
        ar_send(4'd7, 32'h2000, 8'd1);
        wait_drain("miss_drain");
        ar_send(4'd1, 32'hFF8, 8'd3);
        wait_drain("cross_drain");

        // Full queue
        @(posedge clk); #1; rready = 1'b0;
        for (int i = 0; i < 5; i++) ar_send(4'(i), 32'(32'h200 + i * 16), 8'd0);
        @(negedge clk);
        check_eq("full_arready", {63'd0, arready}, 64'd0);
        check_eq("full_qcnt", {61'd0, q_cnt}, 64'd4);
        @(posedge clk); #1; rready = 1'b1;
        @(posedge clk); #1; rready = 1'b0;
        @(negedge clk);
        check_eq("refill_arready", {63'd0, arready}, 64'd1);
        check_eq("refill_qcnt", {61'd0, q_cnt}, 64'd3);
        @(posedge clk); #1; rready = 1'b1;
        wait_drain("full_drain");

        // Back-to-back len=0 bursts: no bubble
        @(posedge clk); #1; rready = 1'b0;
        ar_send(4'd8, 32'h300, 8'd0);
        ar_send(4'd9, 32'h304, 8'd0);
        @(posedge clk); #1; rready = 1'b1;
        @(negedge clk);
        check_eq("b2b_v0", {63'd0, rvalid}, 64'd1);
        @(negedge clk);
        check_eq("b2b_v1", {63'd0, rvalid}, 64'd1);
        check_eq("b2b_id1", {60'd0, rid}, 64'd9);
        @(negedge clk);
        check_eq("b2b_v2", {63'd0, rvalid}, 64'd0);
        wait_drain("b2b_drain");

        // Maximum length burst
        ar_send(4'd2, 32'h0, 8'd255);
        wait_drain("len255_drain");

        // Reset on beat 2 of a len=7 burst
        ar_send(4'd4, 32'h40, 8'd7);
        ar_send(4'd6, 32'h80, 8'd1);
        begin
            int n;
            n = 0;
            while (!rvalid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_eq("rst_mid_wait", {63'd0, rvalid}, 64'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
        check_eq("mid_rst_qcnt", {61'd0, q_cnt}, 64'd0);
        check_eq("mid_rst_arready", {63'd0, arready}, 64'd1);
        sb_q.delete();
        #20;
        rst_n = 1'b1;
        single_hit("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
